// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: DCO FSM encoding, default widths and half-period clamp limits.
package adpll_pkg;
  localparam int DCO_CC_WIDTH       = 9;
  localparam int CNT_WIDTH          = 12;
  localparam int CENTRE_HALF_PERIOD = 256;
  localparam int HALF_PERIOD_MIN    = 4;
  localparam int HALF_PERIOD_MAX    = 1023;
  localparam int CC_FRAC_BITS       = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } dco_state_e;
endpackage

// File: rtl/dco_period_calc.sv
// Control code -> clamped half-period. With DCO_FRAC_EN defined the low code bits are a
// fraction whose accumulator carry shortens the half-period by one cycle.
module dco_period_calc #(
  parameter int DCO_CC_WIDTH       = adpll_pkg::DCO_CC_WIDTH,
  parameter int CNT_WIDTH          = adpll_pkg::CNT_WIDTH,
  parameter int CENTRE_HALF_PERIOD = adpll_pkg::CENTRE_HALF_PERIOD,
  parameter int HALF_PERIOD_MIN    = adpll_pkg::HALF_PERIOD_MIN,
  parameter int HALF_PERIOD_MAX    = adpll_pkg::HALF_PERIOD_MAX,
  parameter int CC_FRAC_BITS       = adpll_pkg::CC_FRAC_BITS
) (
  input  logic signed [DCO_CC_WIDTH-1:0] cc,
`ifdef DCO_FRAC_EN
  input  logic [CC_FRAC_BITS-1:0]        frac_acc,
  output logic [CC_FRAC_BITS-1:0]        frac_acc_nxt,
`endif
  output logic [CNT_WIDTH-1:0]           hp,
  output logic                           sat
);
  localparam int W = CNT_WIDTH + 2;
  localparam logic signed [W-1:0] CENTRE_S = W'(CENTRE_HALF_PERIOD);
  localparam logic signed [W-1:0] MIN_S    = W'(HALF_PERIOD_MIN);
  localparam logic signed [W-1:0] MAX_S    = W'(HALF_PERIOD_MAX);

  logic signed [W-1:0] cc_int, hp_raw;

`ifdef DCO_FRAC_EN
  logic [CC_FRAC_BITS:0] acc_sum;
  logic signed [W-1:0]   carry;

  assign cc_int       = W'(cc >>> CC_FRAC_BITS);
  assign acc_sum      = {1'b0, frac_acc} + {1'b0, cc[CC_FRAC_BITS-1:0]};
  assign frac_acc_nxt = acc_sum[CC_FRAC_BITS-1:0];
  assign carry        = W'(acc_sum[CC_FRAC_BITS]);
  assign hp_raw       = CENTRE_S - cc_int - carry;
`else
  assign cc_int = W'(cc);
  assign hp_raw = CENTRE_S - cc_int;
`endif

  always_comb begin
    hp  = hp_raw[CNT_WIDTH-1:0];
    sat = 1'b0;
    if (hp_raw < MIN_S) begin
      hp  = CNT_WIDTH'(HALF_PERIOD_MIN);
      sat = 1'b1;
    end else if (hp_raw > MAX_S) begin
      hp  = CNT_WIDTH'(HALF_PERIOD_MAX);
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/dco_core.sv
// Counter-based DCO: toggles dco_clk_o every applied half-period, retuning only at boundaries.
// Optional fractional control code via macro DCO_FRAC_EN.
module dco_core #(
  parameter int DCO_CC_WIDTH       = adpll_pkg::DCO_CC_WIDTH,
  parameter int CNT_WIDTH          = adpll_pkg::CNT_WIDTH,
  parameter int CENTRE_HALF_PERIOD = adpll_pkg::CENTRE_HALF_PERIOD,
  parameter int HALF_PERIOD_MIN    = adpll_pkg::HALF_PERIOD_MIN,
  parameter int HALF_PERIOD_MAX    = adpll_pkg::HALF_PERIOD_MAX,
  parameter int CC_FRAC_BITS       = adpll_pkg::CC_FRAC_BITS
) (
  input  logic                    gen_clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [DCO_CC_WIDTH-1:0] dco_cc_i,
  output logic                    dco_clk_o,
  output logic                    dco_edge_o,
  output logic [CNT_WIDTH-1:0]    half_period_o,
  output logic                    sat_o
);
  import adpll_pkg::*;

  dco_state_e           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, calc_hp;
  logic                 calc_sat, term, load, toggle, dec;

  assign term = (cnt == '0);

`ifdef DCO_FRAC_EN
  logic [CC_FRAC_BITS-1:0] frac_acc, frac_acc_nxt;
`endif

  dco_period_calc #(
    .DCO_CC_WIDTH      (DCO_CC_WIDTH),
    .CNT_WIDTH         (CNT_WIDTH),
    .CENTRE_HALF_PERIOD(CENTRE_HALF_PERIOD),
    .HALF_PERIOD_MIN   (HALF_PERIOD_MIN),
    .HALF_PERIOD_MAX   (HALF_PERIOD_MAX),
    .CC_FRAC_BITS      (CC_FRAC_BITS)
  ) u_calc (
    .cc          (dco_cc_i),
`ifdef DCO_FRAC_EN
    .frac_acc    (frac_acc),
    .frac_acc_nxt(frac_acc_nxt),
`endif
    .hp          (calc_hp),
    .sat         (calc_sat)
  );

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // A stop request while low ends at once; while high it waits for the phase to finish.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable_i) state_nxt = RUN;
      RUN, STOPPING: begin
        if (!enable_i && !dco_clk_o) state_nxt = IDLE;
        else if (term)               state_nxt = enable_i ? RUN : IDLE;
        else                         state_nxt = enable_i ? RUN : STOPPING;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    toggle = 1'b0;
    dec    = 1'b0;
    unique case (state)
      IDLE: load = enable_i;
      RUN, STOPPING: begin
        if (enable_i || dco_clk_o) begin
          toggle = term;
          load   = term && enable_i;
          dec    = !term;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      cnt           <= '0;
      dco_clk_o     <= 1'b0;
      dco_edge_o    <= 1'b0;
      half_period_o <= CNT_WIDTH'(CENTRE_HALF_PERIOD);
      sat_o         <= 1'b0;
    end else begin
      dco_edge_o <= toggle && !dco_clk_o;
      if (toggle) dco_clk_o <= !dco_clk_o;
      if (load) begin
        cnt           <= calc_hp - 1'b1;
        half_period_o <= calc_hp;
        sat_o         <= calc_sat;
      end else if (dec) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef DCO_FRAC_EN
  always_ff @(posedge gen_clk_i) begin
    if (reset_i)   frac_acc <= '0;
    else if (load) frac_acc <= frac_acc_nxt;
  end
`endif
endmodule

// File: tb/tb_dco_core.sv
// Randomized + directed bench for dco_core against a time-stamped phase model.
module tb_dco_core;
  localparam int CCW = 9;
  localparam int CW  = 12;
`ifdef DCO_FRAC_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  logic           gen_clk_i = 1'b0;
  logic           reset_i   = 1'b1;
  logic           enable_i  = 1'b0;
  logic [CCW-1:0] dco_cc_i  = '0;
  logic           dco_clk_o, dco_edge_o, sat_o;
  logic [CW-1:0]  half_period_o;

  always #5 gen_clk_i = ~gen_clk_i;

  dco_core dut (
    .gen_clk_i    (gen_clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .dco_cc_i     (dco_cc_i),
    .dco_clk_o    (dco_clk_o),
    .dco_edge_o   (dco_edge_o),
    .half_period_o(half_period_o),
    .sat_o        (sat_o)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Model: the next toggle is scheduled at an absolute cycle number when a code is applied.
  bit     m_on, m_clk, m_edge, m_sat;
  int     m_hp = 256, m_acc = 0;
  longint cyc = 0, m_due = 0;

  task automatic model_load(input int cc);
    int raw;
`ifdef DCO_FRAC_EN
    int frac, carry;
    frac  = cc & 1;
    m_acc = m_acc + frac;
    carry = m_acc / 2;
    m_acc = m_acc % 2;
    raw   = 256 - (cc - frac) / 2 - carry;
`else
    raw = 256 - cc;
`endif
    m_sat = (raw < 4) || (raw > 1023);
    m_hp  = (raw < 4) ? 4 : (raw > 1023) ? 1023 : raw;
    m_due = cyc + m_hp;
  endtask

  task automatic model_step(input bit en, input int cc, input bit rst);
    cyc++;
    m_edge = 1'b0;
    if (rst) begin
      m_on = 0; m_clk = 0; m_hp = 256; m_sat = 0; m_acc = 0;
    end else if (!m_on) begin
      if (en) begin
        m_on = 1;
        model_load(cc);
      end
    end else if (!en && !m_clk) begin
      m_on = 0;
    end else if (cyc == m_due) begin
      m_clk  = !m_clk;
      m_edge = m_clk;
      if (en) model_load(cc);
      else    m_on = 0;
    end
  endtask

  task automatic cycle(input bit en, input int cc, input bit rst);
    enable_i = en;
    dco_cc_i = CCW'(cc);
    reset_i  = rst;
    @(posedge gen_clk_i);
    model_step(en, cc, rst);
    #1;
    chk("clk",  dco_clk_o,     m_clk);
    chk("edge", dco_edge_o,    m_edge);
    chk("hp",   half_period_o, m_hp);
    chk("sat",  sat_o,         m_sat);
  endtask

  // Cycles until dco_clk_o changes; returns the limit if it never does.
  task automatic run_to_toggle(input bit en, input int cc, output int k);
    logic prev;
    prev = dco_clk_o;
    k = 0;
    do begin
      cycle(en, cc, 1'b0);
      k++;
    end while (dco_clk_o == prev && k < 2100);
  endtask

  int k, k1, k2, len, cc;
  bit en, rst;

  initial begin
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("rst_clk", dco_clk_o, 0);
    chk("rst_hp", half_period_o, 256);
    chk("rst_sat", sat_o, 0);

    // centre code: first rise one half-period after enable, full period 512
    cycle(1, 0, 0);
    run_to_toggle(1, 0, k);  chk("t1_first_rise", k, 256);
    run_to_toggle(1, 0, k);  run_to_toggle(1, 0, k1);
    chk("t1_period", k + k1, 512);

    // code change mid-phase only applies at the next boundary
    repeat (100) cycle(1, 0, 0);
    run_to_toggle(1, 56 * SCALE, k);
    chk("t2_cur_phase", k + 100, 256);
    chk("t2_hp", half_period_o, 200);
    run_to_toggle(1, 56 * SCALE, k); chk("t2_next_phase", k, 200);

    // clamp limits
`ifndef DCO_FRAC_EN
    run_to_toggle(1, 255, k);
    chk("t3_min_hp", half_period_o, 4);
    chk("t3_min_sat", sat_o, 1);
`endif
    run_to_toggle(1, -256, k);
    chk("t3_neg_hp", half_period_o, (SCALE == 2) ? 384 : 512);
    chk("t3_neg_sat", sat_o, 0);

    // stop while high completes the phase; stop while low is immediate
    run_to_toggle(1, 0, k);
    if (dco_clk_o == 1'b0) run_to_toggle(1, 0, k);
    repeat (100) cycle(1, 0, 0);
    run_to_toggle(0, 0, k);
    chk("t4_high_len", k + 100, 256);
    repeat (300) cycle(0, 0, 0);
    chk("t4_idle_low", dco_clk_o, 0);
    cycle(1, 0, 0);
    repeat (50) cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    run_to_toggle(1, 0, k);  chk("t4_restart", k, 256);

    // reset mid high phase
    run_to_toggle(1, 56 * SCALE, k);
    run_to_toggle(1, 56 * SCALE, k);
    repeat (50) cycle(1, 56 * SCALE, 0);
    cycle(1, 0, 1);
    chk("t5_clk", dco_clk_o, 0);
    chk("t5_edge", dco_edge_o, 0);
    chk("t5_hp", half_period_o, 256);
    chk("t5_sat", sat_o, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    run_to_toggle(1, 0, k);  chk("t5_restart", k, 256);

    // odd code: fractional build dithers 256/255, integer build holds 255
    run_to_toggle(1, 1, k);
    run_to_toggle(1, 1, k1);
    run_to_toggle(1, 1, k2);
    chk("t6_pair", k1 + k2, (SCALE == 2) ? 511 : 510);
`ifdef DCO_FRAC_EN
    chk("t6_dither", (k1 == k2) ? 1 : 0, 0);
`else
    chk("t6_const", k1, 255);
`endif

    // randomized segments
    for (int s = 0; s < 1500; s++) begin
      len = $urandom_range(1, 40);
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 7) cc = $urandom_range(200, 255);
      else                          cc = int'($urandom_range(0, 511)) - 256;
      for (int i = 0; i < len; i++) cycle(en, cc, rst && (i == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
